bcd_mod_counter: RTL

- Parametrised two-digit BCD modulo counter; generalised successor of the fixed 0–59 stopwatch counter.
- Adds configurable modulus (2–100), up/down counting, synchronous preset load with range check, and a borrow output.
- Serves stopwatch/timer/clock chains: seconds/minutes (MOD=60), hours (MOD=24/12), countdown timers (down mode).
- CA/BR cascade combinationally into the next stage's INC/DEC, so a whole chain advances in the same clock.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit.sv | 50 +++++
 rtl/bcd_mod_counter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, constants and helpers
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Tens digit of a binary value 0..99
   function automatic bcd_digit_t tens_of(input int n);
      return bcd_digit_t'((n / 10) % 10);
   endfunction

   // Units digit of a binary value 0..99
   function automatic bcd_digit_t units_of(input int n);
      return bcd_digit_t'(n % 10);
   endfunction

   // True when the nibble is a legal decimal digit
   function automatic logic is_bcd(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade with clear, load, wrap and up/down step
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       up_i,
   input  logic       dn_i,
   input  logic       load_i,
   input  bcd_digit_t load_val_i,
   input  logic       wrap_i,
   input  bcd_digit_t wrap_val_i,
   output bcd_digit_t digit_o,
   output logic       at9_o,
   output logic       at0_o
);

   bcd_digit_t digit_q, digit_d;

   // Next digit: clear beats load beats modulus wrap beats a plain decade step
   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = '0;
      end else if (load_i) begin
         digit_d = load_val_i;
      end else if (wrap_i) begin
         digit_d = wrap_val_i;
      end else if (up_i) begin
         digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else if (dn_i) begin
         digit_d = (digit_q == 4'd0 || digit_q > BCD_MAX) ? BCD_MAX : digit_q - 4'd1;
      end
   end

   // Digit register, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;
   assign at9_o   = (digit_q == BCD_MAX);
   assign at0_o   = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter with up/down, load and cascade
module bcd_mod_counter
   import bcd_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLR,
   input  logic       EN,
   input  logic       UP,
   input  logic       INC,
   input  logic       DEC,
   input  logic       LD,
   input  logic [3:0] DH,
   input  logic [3:0] DL,
   output logic [3:0] QH,
   output logic [3:0] QL,
   output logic       CA,
   output logic       BR,
   output logic       ZERO,
   output logic       LDERR
);

   generate
      if (MOD < 2 || MOD > 100) begin : g_bad_mod
         $error("bcd_mod_counter: MOD must lie in 2..100");
      end
   endgenerate

   localparam bcd_digit_t TERM_H = tens_of(MOD - 1);
   localparam bcd_digit_t TERM_L = units_of(MOD - 1);
   localparam logic [7:0] TERM_B = 8'(MOD - 1);

   bcd_digit_t qh, ql;
   logic       ql_at9, ql_at0, qh_at9, qh_at0;
   logic [7:0] cur_bin, ld_bin;
   logic       at_term, at_zero, in_range, ld_ok;
   logic       up_raw, dn_raw, go_up, go_dn, wrap_up, wrap_dn, wrap_any;
   logic       load_en;
   bcd_digit_t wrap_h, wrap_l;
   logic       lderr_q, lderr_d;

   assign cur_bin  = ({4'd0, qh} * 8'd10) + {4'd0, ql};
   assign ld_bin   = ({4'd0, DH} * 8'd10) + {4'd0, DL};

   assign at_term  = (qh == TERM_H) && (ql == TERM_L);
   assign at_zero  = qh_at0 && ql_at0;
   assign in_range = is_bcd(qh) && is_bcd(ql) && (cur_bin <= TERM_B);
   assign ld_ok    = is_bcd(DH) && is_bcd(DL) && (ld_bin <= TERM_B);

   // Opposite requests in one cycle cancel; CLR and LD swallow any step
   assign up_raw   = (EN & UP) | INC;
   assign dn_raw   = (EN & ~UP) | DEC;
   assign go_up    = up_raw & ~dn_raw & ~CLR & ~LD;
   assign go_dn    = dn_raw & ~up_raw & ~CLR & ~LD;

   // Terminal/zero crossings and any corrupted state jump straight to the wrap value
   assign wrap_up  = go_up & (at_term | ~in_range);
   assign wrap_dn  = go_dn & (at_zero | ~in_range);
   assign wrap_any = wrap_up | wrap_dn;
   assign wrap_h   = wrap_up ? 4'd0 : TERM_H;
   assign wrap_l   = wrap_up ? 4'd0 : TERM_L;

   assign load_en  = LD & ld_ok;

   bcd_digit u_units (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .clr_i      (CLR),
      .up_i       (go_up),
      .dn_i       (go_dn),
      .load_i     (load_en),
      .load_val_i (DL),
      .wrap_i     (wrap_any),
      .wrap_val_i (wrap_l),
      .digit_o    (ql),
      .at9_o      (ql_at9),
      .at0_o      (ql_at0)
   );

   bcd_digit u_tens (
      .clk_i      (CLK),
      .rst_ni     (RST),
      .clr_i      (CLR),
      .up_i       (go_up & ql_at9),
      .dn_i       (go_dn & ql_at0),
      .load_i     (load_en),
      .load_val_i (DH),
      .wrap_i     (wrap_any),
      .wrap_val_i (wrap_h),
      .digit_o    (qh),
      .at9_o      (qh_at9),
      .at0_o      (qh_at0)
   );

   // A rejected load flags for exactly the following cycle
   always_comb begin
      lderr_d = LD & ~CLR & ~ld_ok;
   end

   // Load-error pulse register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lderr_q <= 1'b0;
      end else begin
         lderr_q <= lderr_d;
      end
   end

   assign QH    = qh;
   assign QL    = ql;
   assign CA    = go_up & at_term & RST;
   assign BR    = go_dn & at_zero & RST;
   assign ZERO  = at_zero;
   assign LDERR = lderr_q;

   logic unused_ok;
   assign unused_ok = qh_at9;

endmodule
